// File: rtl/bus_ctrl_pkg.sv
// rtl/bus_ctrl_pkg.sv - shared types and constants for the coherence bus controller and its L2 target
package bus_ctrl_pkg;

   localparam int CPUS       = 2;
   localparam int BLOCK_SIZE = 2;
   localparam int DATA_WIDTH = 32 * BLOCK_SIZE;

   typedef logic [31:0]               word_t;
   typedef logic [DATA_WIDTH-1:0]     transfer_width_t;
   typedef logic [CPUS-1:0]           cpus_bitvec_t;
   typedef logic [$clog2(CPUS)-1:0]   cpuid_t;

   typedef enum logic [1:0] {
      L2_FREE   = 2'd0,
      L2_BUSY   = 2'd1,
      L2_ACCESS = 2'd2,
      L2_ERROR  = 2'd3
   } l2_state_t;

   typedef enum logic [2:0] {
      BUS_IDLE      = 3'd0,
      BUS_ARBITRATE = 3'd1,
      BUS_SNOOP     = 3'd2,
      BUS_L2_REQ    = 3'd3,
      BUS_L2_WAIT   = 3'd4,
      BUS_RESPOND   = 3'd5
   } bus_state_t;

endpackage

// File: rtl/l2_sram.sv
// rtl/l2_sram.sv - single-port block array, synchronous read and write
// The read register only loads on read strobes, so it holds the last read value across writes.
module l2_sram #(
   parameter int DEPTH = 1024,
   parameter int WIDTH = 64,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic             i_we,
   input  logic [AW-1:0]    i_addr,
   input  logic [WIDTH-1:0] i_wdata,
   output logic [WIDTH-1:0] o_rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rdata;

   always_ff @(posedge clk) begin
      if (i_en && i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (i_rst) begin
         r_rdata <= '0;
      end else if (i_en && !i_we) begin
         r_rdata <= r_mem[i_addr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/l2_mem_ctrl.sv
// rtl/l2_mem_ctrl.sv - dummy L2 target: fixed-latency block read/write behind the l2 state handshake
// Holds only the FSM, latency counter, address check, request latches and statistics.
module l2_mem_ctrl #(
   parameter int          BLOCK_SIZE = 2,
   parameter int          DEPTH      = 1024,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
   parameter int          LATENCY    = 4
) (
   input  logic                      clk,
   input  logic                      RST,
   input  logic                      l2REN,
   input  logic                      l2WEN,
   input  logic [31:0]               l2addr,
   input  logic [32*BLOCK_SIZE-1:0]  l2store,
   output logic [32*BLOCK_SIZE-1:0]  l2load,
   output logic [1:0]                l2state,
   output logic [31:0]               rd_count,
   output logic [31:0]               wr_count
);
   import bus_ctrl_pkg::*;

   localparam int DW  = 32 * BLOCK_SIZE;
   localparam int OFS = $clog2(BLOCK_SIZE) + 2;
   localparam int IW  = $clog2(DEPTH);
   localparam int CW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [32:0]   END_ADDR = {1'b0, BASE_ADDR} + 33'(DEPTH * 4 * BLOCK_SIZE);
   localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

   l2_state_t        r_state;
   l2_state_t        w_state_nxt;
   logic [CW-1:0]    r_cnt;
   logic             r_is_wr;
   logic [IW-1:0]    r_idx;
   logic [DW-1:0]    r_data;
   logic [31:0]      r_rd_count;
   logic [31:0]      r_wr_count;

   logic             w_req;
   logic             w_both;
   logic             w_bad_addr;
   logic [32:0]      w_off;
   logic [IW-1:0]    w_idx;
   logic             w_accept;
   logic             w_mem_en;

   // 33-bit offset: bit 32 set means the address sits below BASE_ADDR
   assign w_off      = {1'b0, l2addr} - {1'b0, BASE_ADDR};
   assign w_idx      = IW'(w_off[31:0] >> OFS);
   assign w_bad_addr = (|l2addr[OFS-1:0]) | w_off[32] | ({1'b0, l2addr} >= END_ADDR);
   assign w_req      = l2REN | l2WEN;
   assign w_both     = l2REN & l2WEN;

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_mem_en    = 1'b0;
      case (r_state)
         L2_FREE: begin
            if (w_req) begin
               if (w_both || w_bad_addr) begin
                  w_state_nxt = L2_ERROR;
               end else begin
                  w_state_nxt = L2_BUSY;
                  w_accept    = 1'b1;
               end
            end
         end
         L2_BUSY: begin
            if (!w_req) begin
               w_state_nxt = L2_FREE;
            end else if (r_cnt == '0) begin
               w_state_nxt = L2_ACCESS;
               // a reset on this edge must discard the in-flight write
               w_mem_en    = !RST;
            end
         end
         L2_ACCESS: w_state_nxt = L2_FREE;
         L2_ERROR: begin
            if (!w_req) begin
               w_state_nxt = L2_FREE;
            end
         end
         default: w_state_nxt = L2_FREE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         r_state    <= L2_FREE;
         r_cnt      <= '0;
         r_is_wr    <= 1'b0;
         r_idx      <= '0;
         r_data     <= '0;
         r_rd_count <= '0;
         r_wr_count <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_cnt   <= CNT_INIT;
            r_is_wr <= l2WEN;
            r_idx   <= w_idx;
            r_data  <= l2store;
         end else if (r_state == L2_BUSY && r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
         end
         if (r_state == L2_ACCESS) begin
            if (r_is_wr) begin
               r_wr_count <= r_wr_count + 32'd1;
            end else begin
               r_rd_count <= r_rd_count + 32'd1;
            end
         end
      end
   end

   l2_sram #(
      .DEPTH (DEPTH),
      .WIDTH (DW)
   ) u_sram (
      .clk     (clk),
      .i_rst   (RST),
      .i_en    (w_mem_en),
      .i_we    (r_is_wr),
      .i_addr  (r_idx),
      .i_wdata (r_data),
      .o_rdata (l2load)
   );

   assign l2state  = r_state;
   assign rd_count = r_rd_count;
   assign wr_count = r_wr_count;

endmodule

// File: tb/tb_l2_mem_ctrl.sv
// tb/tb_l2_mem_ctrl.sv - directed scoreboard bench for l2_mem_ctrl at LATENCY 4 and LATENCY 1
module tb_l2_mem_ctrl;
   import bus_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        RST;
   logic        ren4, wen4, ren1, wen1;
   logic [31:0] l2addr;
   logic [63:0] l2store;
   logic [63:0] ld4, ld1;
   logic [1:0]  st4, st1;
   logic [31:0] rc4, wc4, rc1, wc1;

   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc   = 0;
   logic [63:0] model [0:1023];
   logic [63:0] exp_q [$];
   int          exp_rd [2];
   int          exp_wr [2];
   logic [63:0] last_rd [2];

   always #5 clk = ~clk;

   l2_mem_ctrl #(.BLOCK_SIZE(2), .DEPTH(1024), .BASE_ADDR(32'h0), .LATENCY(4)) dut4 (
      .clk(clk), .RST(RST), .l2REN(ren4), .l2WEN(wen4), .l2addr(l2addr), .l2store(l2store),
      .l2load(ld4), .l2state(st4), .rd_count(rc4), .wr_count(wc4));

   l2_mem_ctrl #(.BLOCK_SIZE(2), .DEPTH(1024), .BASE_ADDR(32'h0), .LATENCY(1)) dut1 (
      .clk(clk), .RST(RST), .l2REN(ren1), .l2WEN(wen1), .l2addr(l2addr), .l2store(l2store),
      .l2load(ld1), .l2state(st1), .rd_count(rc1), .wr_count(wc1));

   function automatic logic [63:0] pre(input int i);
      return {32'hA5A5_0000 | 32'(i), 32'h5A5A_0000 | 32'(i)};
   endfunction

   function automatic logic [1:0] st(input int sel);
      return (sel != 0) ? st1 : st4;
   endfunction

   function automatic logic [63:0] ld(input int sel);
      return (sel != 0) ? ld1 : ld4;
   endfunction

   function automatic logic [31:0] rcnt(input int sel);
      return (sel != 0) ? rc1 : rc4;
   endfunction

   function automatic logic [31:0] wcnt(input int sel);
      return (sel != 0) ? wc1 : wc4;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int sel, input logic ren, input logic wen);
      if (sel != 0) begin
         ren1 = ren; wen1 = wen;
      end else begin
         ren4 = ren; wen4 = wen;
      end
   endtask

   task automatic chk_counts(input string tag, input int sel);
      chk({tag, "_rd_count"}, 64'(rcnt(sel)), 64'(exp_rd[sel]));
      chk({tag, "_wr_count"}, 64'(wcnt(sel)), 64'(exp_wr[sel]));
   endtask

   // Full access: BUSY for lat cycles, ACCESS on lat+1, then FREE after the request drops
   task automatic access(input int sel, input logic ren, input logic wen, input logic [31:0] addr,
                         input logic [63:0] data, input int lat, input bit scramble, output int acc_cyc);
      int          idx;
      logic [63:0] exp;
      idx = int'(addr >> 3);
      if (ren) exp_q.push_back(model[idx]);
      l2addr  = addr;
      l2store = data;
      set_req(sel, ren, wen);
      tick();
      for (int c = 1; c <= lat; c++) begin
         chk("busy", 64'(st(sel)), 64'(L2_BUSY));
         if (scramble) begin
            l2addr  = $urandom;
            l2store = {$urandom, $urandom};
         end
         tick();
      end
      chk("access", 64'(st(sel)), 64'(L2_ACCESS));
      acc_cyc = cyc;
      if (ren) begin
         exp = exp_q.pop_front();
         chk("rdata", ld(sel), exp);
         last_rd[sel] = exp;
         exp_rd[sel]++;
      end else begin
         chk("load_hold_on_write", ld(sel), last_rd[sel]);
         model[idx] = data;
         exp_wr[sel]++;
      end
      set_req(sel, 1'b0, 1'b0);
      tick();
      chk("free_after_access", 64'(st(sel)), 64'(L2_FREE));
   endtask

   task automatic err_case(input string tag, input logic ren, input logic wen, input logic [31:0] addr);
      l2addr = addr;
      set_req(0, ren, wen);
      tick();
      chk({tag, "_error"}, 64'(st4), 64'(L2_ERROR));
      tick();
      chk({tag, "_error_held"}, 64'(st4), 64'(L2_ERROR));
      chk({tag, "_load_kept"}, ld4, last_rd[0]);
      set_req(0, 1'b0, 1'b0);
      tick();
      chk({tag, "_free"}, 64'(st4), 64'(L2_FREE));
      chk_counts(tag, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, t1, t2;
      RST = 1'b1;
      ren4 = 1'b0; wen4 = 1'b0; ren1 = 1'b0; wen1 = 1'b0;
      l2addr = '0; l2store = '0;
      exp_rd = '{0, 0}; exp_wr = '{0, 0}; last_rd = '{64'h0, 64'h0};
      for (int i = 0; i < 64; i++) begin
         dut4.u_sram.r_mem[i] = pre(i);
         dut1.u_sram.r_mem[i] = pre(i);
         model[i] = pre(i);
      end

      tick();
      tick();
      RST = 1'b0;
      chk("reset_state", 64'(st4), 64'(L2_FREE));
      chk("reset_load", ld4, 64'h0);
      chk_counts("reset", 0);
      chk("reset_state_lat1", 64'(st1), 64'(L2_FREE));

      // abort: write dropped in the 2nd BUSY cycle
      l2addr = 32'h80; l2store = 64'h1111_2222_3333_4444;
      set_req(0, 1'b0, 1'b1);
      tick();
      chk("abort_busy1", 64'(st4), 64'(L2_BUSY));
      tick();
      chk("abort_busy2", 64'(st4), 64'(L2_BUSY));
      set_req(0, 1'b0, 1'b0);
      tick();
      chk("abort_free", 64'(st4), 64'(L2_FREE));
      access(0, 1'b1, 1'b0, 32'h80, 64'h0, 4, 1'b0, t0);
      chk_counts("abort", 0);

      // write then read same block
      access(0, 1'b0, 1'b1, 32'h40, 64'hDEAD_BEEF_0123_4567, 4, 1'b0, t0);
      access(0, 1'b1, 1'b0, 32'h40, 64'h0, 4, 1'b0, t1);
      chk("raw_data", ld4, 64'hDEAD_BEEF_0123_4567);
      chk("raw_spacing", 64'(t1 - t0), 64'd6);
      chk_counts("raw", 0);

      // error cases
      err_case("misaligned", 1'b1, 1'b0, 32'h44);
      err_case("range", 1'b1, 1'b0, 32'h2000);
      err_case("both", 1'b1, 1'b1, 32'h40);
      access(0, 1'b1, 1'b0, 32'h40, 64'h0, 4, 1'b0, t0);

      // inputs wiggle during BUSY; latched index and data must win
      access(0, 1'b0, 1'b1, 32'h100, 64'hCAFE_F00D_1234_5678, 4, 1'b1, t0);
      access(0, 1'b1, 1'b0, 32'h100, 64'h0, 4, 1'b0, t0);
      chk("latched_data", ld4, 64'hCAFE_F00D_1234_5678);
      access(0, 1'b1, 1'b0, 32'h38, 64'h0, 4, 1'b0, t0);
      chk_counts("latched", 0);

      // reset in the last BUSY cycle of a write
      l2addr = 32'hC0; l2store = 64'hBAD0_BAD0_BAD0_BAD0;
      set_req(0, 1'b0, 1'b1);
      tick();
      for (int c = 1; c <= 4; c++) begin
         chk("rst_busy", 64'(st4), 64'(L2_BUSY));
         if (c < 4) tick();
      end
      RST = 1'b1;
      set_req(0, 1'b0, 1'b0);
      tick();
      chk("rst_free", 64'(st4), 64'(L2_FREE));
      RST = 1'b0;
      exp_rd = '{0, 0}; exp_wr = '{0, 0}; last_rd = '{64'h0, 64'h0};
      chk("rst_load", ld4, 64'h0);
      chk_counts("rst", 0);
      access(0, 1'b1, 1'b0, 32'hC0, 64'h0, 4, 1'b0, t0);
      chk("rst_not_committed", ld4, pre(24));

      // back-to-back reads at LATENCY 1
      access(1, 1'b1, 1'b0, 32'h08, 64'h0, 1, 1'b0, t0);
      access(1, 1'b1, 1'b0, 32'h10, 64'h0, 1, 1'b0, t1);
      access(1, 1'b1, 1'b0, 32'h18, 64'h0, 1, 1'b0, t2);
      chk("b2b_spacing1", 64'(t1 - t0), 64'd3);
      chk("b2b_spacing2", 64'(t2 - t1), 64'd3);
      chk("b2b_last_data", ld1, pre(3));
      chk_counts("b2b", 1);
      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
